alu_seq_ctrl: RTL
=================

Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer that owns the 16-bit combinational ALU (ADD/SUB R/I, LSL/LSR by 1) and builds longer operations from single ALU passes: unsigned multiply (low 16 bits) and shift by N (0-15).
- Sits beside the execute stage and drives the ALU operand/opcode inputs while busy.
- Uses a start/busy/done handshake with the CPU control unit.

Parameters:
- WIDTH, 16, datapath width; must equal the ALU width.
- CNT_W, 4, shift-count width (uses b[CNT_W-1:0]).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  2  00=MUL, 01=SHL_N, 10=SHR_N, 11=reserved (pass-through)
- a  in  16  multiplicand / shift source
- b  in  16  multiplier / shift count in b[3:0]
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result valid
- result  out  16  registered result, held until the next accepted start
- alu_rsdata  out  16  to ALU rsdata
- alu_rmdata  out  16  to ALU rmdata
- alu_n  out  16  to ALU N, always 0
- alu_instr_bit_15  out  1  ALU opcode bit 2
- alu_instr_bit_12_11  out  2  ALU opcode bits 1:0
- alu_aluout  in  16  from ALU aluout

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, internal P/M/Q/R/cnt=0. Applies mid-operation and discards the operation without asserting done.
- ALU opcode is {bit15, bits12_11}: 000 ADD R, 100 LSL, 110 LSR, 111 idle (ALU outputs 0).
- In any state that does not use the ALU, drive opcode 111 and operands 0. Drive the ALU combinationally from state; capture alu_aluout at the clock edge.
- States: IDLE, TEST, ADD, SHL, SHR, SHIFT, DONE.
- IDLE:
  - start=1 with op=MUL: P<=0, M<=a, Q<=b, go to TEST.
  - start=1 with op=01/10: R<=a, cnt<=b[3:0], dir latched, go to SHIFT.
  - start=1 with op=11: R<=a, cnt<=0, go to SHIFT.
- TEST: if Q==0, go to DONE with result<=P. Otherwise go to ADD if Q[0]=1, else SHL.
- ADD: rs=P, rm=M, opcode 000; P<=alu_aluout (mod 2^16, carry dropped). Next state SHL.
- SHL: rs=M, opcode 100; M<=alu_aluout. Next state SHR.
- SHR: rs=Q, opcode 110; Q<=alu_aluout. Next state TEST.
- SHIFT:
  - cnt==0: go to DONE with result<=R.
  - Otherwise: rs=R, opcode 100 (SHL_N) or 110 (SHR_N); R<=alu_aluout; cnt<=cnt-1; stay in SHIFT.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start is ignored in DONE.
- busy=1 in TEST/ADD/SHL/SHR/SHIFT. start while busy is ignored; a, b and op changes while busy have no effect.
- Latency, counted from the start-sampling edge (cycle 0) to the done cycle:
  - MUL: 3k + popcount(b) + 2, where k = index of the highest set bit of b plus 1 (k=0 when b=0). Minimum 2, maximum 66.
  - SHL_N/SHR_N: n+2.
  - Reserved op: 2.
- Back-to-back: a new start is accepted in the IDLE cycle directly after DONE.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum;
  - ALU opcode constants OP_ADD_R=3'b000, OP_ADD_I=3'b001, OP_SUB_R=3'b010, OP_SUB_I=3'b011, OP_LSL=3'b100, OP_LSR=3'b110, OP_IDLE=3'b111;
  - request op codes REQ_MUL, REQ_SHL, REQ_SHR, REQ_PASS.
- One optional sub-module, alu_seq_drive: a purely combinational state-to-ALU operand/opcode mux. The FSM and registers stay in alu_seq_ctrl.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- MUL a=0x0003, b=0x0005 -> result=0x000F; done in cycle 13; busy high in cycles 1-12; ADD state visited twice.
- MUL a=0x1234, b=0x0000 -> result=0x0000, done in cycle 2. MUL a=0xFFFF, b=0xFFFF -> result=0x0001, done in cycle 66.
- SHL_N a=0x8001, b=0x0001 -> result=0x0002, done in cycle 3. SHR_N a=0x8000, b=0x000F -> result=0x0001, done in cycle 17. SHL_N b=0x0000 -> result=a, cycle 2.
- Start pulse with different a/b in cycle 5 of MUL 3x5 -> ignored; result still 0x000F at cycle 13. Second start in the cycle after done -> accepted.
- reset=1 in cycle 6 of MUL 0xFFFF x 0xFFFF -> next cycle busy=0, done=0, result=0, ALU opcode 111; done never pulses for the aborted operation.
- op=11, a=0xBEEF -> result=0xBEEF, done in cycle 2. Throughout all tests, check that ALU opcode is 111 in IDLE/TEST/DONE and alu_n is always 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared state encodings, ALU opcodes and request codes for the ALU sequencer.
// The ALU opcode is the concatenation {instr[15], instr[12:11]}.
package alu_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_TEST  = 3'd1;
    localparam state_t S_ADD   = 3'd2;
    localparam state_t S_SHL   = 3'd3;
    localparam state_t S_SHR   = 3'd4;
    localparam state_t S_SHIFT = 3'd5;
    localparam state_t S_DONE  = 3'd6;

    localparam logic [2:0] OP_ADD_R = 3'b000;
    localparam logic [2:0] OP_ADD_I = 3'b001;
    localparam logic [2:0] OP_SUB_R = 3'b010;
    localparam logic [2:0] OP_SUB_I = 3'b011;
    localparam logic [2:0] OP_LSL   = 3'b100;
    localparam logic [2:0] OP_LSR   = 3'b110;
    localparam logic [2:0] OP_IDLE  = 3'b111;

    localparam logic [1:0] REQ_MUL  = 2'b00;
    localparam logic [1:0] REQ_SHL  = 2'b01;
    localparam logic [1:0] REQ_SHR  = 2'b10;
    localparam logic [1:0] REQ_PASS = 2'b11;

endpackage

// File: rtl/alu_seq_drive.sv
// Combinational mux from sequencer state to ALU operands and opcode.
// States that do not use the ALU park it on the idle opcode with zero operands.
module alu_seq_drive
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  state_t             state,
    input  logic               shift_active,
    input  logic               shift_right,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   r,
    output logic [WIDTH-1:0]   rsdata,
    output logic [WIDTH-1:0]   rmdata,
    output logic [2:0]         opcode
);

    always_comb begin
        rsdata = '0;
        rmdata = '0;
        opcode = OP_IDLE;
        case (state)
            S_ADD: begin
                rsdata = p;
                rmdata = m;
                opcode = OP_ADD_R;
            end
            S_SHL: begin
                rsdata = m;
                opcode = OP_LSL;
            end
            S_SHR: begin
                rsdata = q;
                opcode = OP_LSR;
            end
            S_SHIFT: begin
                if (shift_active) begin
                    rsdata = r;
                    opcode = shift_right ? OP_LSR : OP_LSL;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer building multiply and shift-by-N out of single ALU passes.
// Multiply is shift-and-add: P accumulates M while Q is consumed one bit per round.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_rsdata,
    output logic [WIDTH-1:0] alu_rmdata,
    output logic [WIDTH-1:0] alu_n,
    output logic             alu_instr_bit_15,
    output logic [1:0]       alu_instr_bit_12_11,
    input  logic [WIDTH-1:0] alu_aluout
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   p_q, p_d, m_q, m_d, q_q, q_d, r_q, r_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [2:0]         alu_opcode;

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        m_d      = m_q;
        q_d      = q_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        REQ_MUL: begin
                            p_d     = '0;
                            m_d     = a;
                            q_d     = b;
                            state_d = S_TEST;
                        end
                        REQ_SHL, REQ_SHR: begin
                            r_d     = a;
                            cnt_d   = b[CNT_W-1:0];
                            dir_d   = (op == REQ_SHR);
                            state_d = S_SHIFT;
                        end
                        default: begin
                            r_d     = a;
                            cnt_d   = '0;
                            state_d = S_SHIFT;
                        end
                    endcase
                end
            end
            S_TEST: begin
                if (q_q == '0) begin
                    result_d = p_q;
                    state_d  = S_DONE;
                end else begin
                    state_d = q_q[0] ? S_ADD : S_SHL;
                end
            end
            S_ADD: begin
                p_d     = alu_aluout;
                state_d = S_SHL;
            end
            S_SHL: begin
                m_d     = alu_aluout;
                state_d = S_SHR;
            end
            S_SHR: begin
                q_d     = alu_aluout;
                state_d = S_TEST;
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    result_d = r_q;
                    state_d  = S_DONE;
                end else begin
                    r_d   = alu_aluout;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            m_q      <= m_d;
            q_q      <= q_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            result_q <= result_d;
        end
    end

    alu_seq_drive #(
        .WIDTH (WIDTH)
    ) u_drive (
        .state        (state_q),
        .shift_active (cnt_q != '0),
        .shift_right  (dir_q),
        .p            (p_q),
        .m            (m_q),
        .q            (q_q),
        .r            (r_q),
        .rsdata       (alu_rsdata),
        .rmdata       (alu_rmdata),
        .opcode       (alu_opcode)
    );

    assign busy                = (state_q == S_TEST) || (state_q == S_ADD) ||
                                 (state_q == S_SHL)  || (state_q == S_SHR) ||
                                 (state_q == S_SHIFT);
    assign done                = (state_q == S_DONE);
    assign result              = result_q;
    assign alu_n               = '0;
    assign alu_instr_bit_15    = alu_opcode[2];
    assign alu_instr_bit_12_11 = alu_opcode[1:0];

endmodule
